l2_lint_arbiter: RTL and testbench
==================================

Name: l2_lint_arbiter

Overview:
- Shares one single-port L2 bank lint slave between two lint masters.
- Master 0 is the JTAG lint master; master 1 is a second SoC requester, e.g. a test DMA.
- Round-robin arbitration on requests.
- In-order response routing through an ID FIFO that tracks outstanding transactions.
- Sits between the lint JTAG wrapper / second master and the multi-bank L2 RAM `mem_slave` port.

Parameters:
- ADDR_WIDTH, 32, lint address width.
- DATA_WIDTH, 32, lint data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, depth of the response-ID FIFO; power of two, ≥2.
- RESET_PRIO, 0, master that wins the first contended cycle after reset.

Ports:
- clk_i  in  1  clock; only clock of the block.
- rst_i  in  1  reset; synchronous, active-high.
- m0_req_i  in  1  master 0 request.
- m0_add_i  in  ADDR_WIDTH  master 0 address.
- m0_wen_i  in  1  master 0 write-enable-low (1 = read, 0 = write).
- m0_be_i  in  DATA_WIDTH/8  master 0 byte enables.
- m0_wdata_i  in  DATA_WIDTH  master 0 write data.
- m0_gnt_o  out  1  master 0 grant.
- m0_r_valid_o  out  1  master 0 response valid.
- m0_r_rdata_o  out  DATA_WIDTH  master 0 read data.
- m1_*  same set as m0_*, for master 1.
- s_req_o  out  1  request to L2.
- s_add_o  out  ADDR_WIDTH  address to L2.
- s_wen_o  out  1  write-enable-low to L2.
- s_be_o  out  DATA_WIDTH/8  byte enables to L2.
- s_wdata_o  out  DATA_WIDTH  write data to L2.
- s_gnt_i  in  1  L2 grant.
- s_r_valid_i  in  1  L2 response valid.
- s_r_rdata_i  in  DATA_WIDTH  L2 read data.
- err_o  out  1  sticky protocol error flag.

Behaviour:
- **Clock/reset.** One clock (clk_i); reset rst_i is synchronous and active-high.
- **Reset values.**
  - All registered state cleared: FIFO empty, count 0, rr pointer = RESET_PRIO, err_o = 0.
  - m*_gnt_o, m*_r_valid_o and s_req_o are 0 while rst_i is high.
  - Reset asserted mid-operation discards all outstanding IDs; responses already in flight at L2 are not routed (see unmatched-response handling).
- **Request path.** Combinational, zero latency.
  - Eligible = req_i && FIFO not full (count < MAX_OUTSTANDING).
  - Exactly one eligible master: it is selected.
  - Both eligible: master rr_ptr is selected.
  - The selected master's add/wen/be/wdata drive s_*_o, and s_req_o = 1.
  - No master selected: s_req_o = 0 and s_* data = 0.
  - m_sel_gnt_o = s_gnt_i; the non-selected master's gnt = 0.
- **Handshake.**
  - A transaction is accepted when s_req_o && s_gnt_i.
  - Masters hold req and fields stable until gnt.
  - The arbiter does not change selection while s_req_o=1 && s_gnt_i=0 (selection locked until the handshake completes).
- **Round-robin.** On each accepted transaction from master k, rr_ptr <= 1-k. No update without acceptance.
- **ID FIFO.**
  - On acceptance, push the selected master ID (1 bit).
  - Every accepted transaction, read or write, yields exactly one s_r_valid_i, returned in order.
  - On s_r_valid_i, pop the head ID and drive m_head_r_valid_o = 1 and m_head_r_rdata_o = s_r_rdata_i in the same cycle (combinational routing).
  - The other master's r_valid = 0; r_rdata of the non-addressed master = 0.
  - Push and pop in the same cycle: count unchanged, both pointers advance; legal when full.
  - Full: no grants (s_req_o=0) unless a pop happens in the same cycle. Using registered count, no grant is issued that cycle at all; the full stall always costs ≥1 cycle.
  - Wrap-around: pointers are log2(MAX_OUTSTANDING) bits and wrap naturally.
- **Error.** s_r_valid_i with FIFO empty: response dropped (no m*_r_valid_o), err_o <= 1 and held until reset.
- **Throughput.** One transaction per cycle when s_gnt_i=1 and the FIFO is not full.

Test Plan:
- **Single master read.** m0 reads 0x1C000010, L2 gnt immediately, r_valid next cycle with 0xDEADBEEF.
  - m0_gnt_o=1 in the request cycle; m0_r_valid_o=1 with 0xDEADBEEF one cycle later.
  - m1 signals stay 0; err_o=0.
- **Contention.** m0 and m1 both request continuously for 6 cycles, s_gnt_i=1, rr reset value 0.
  - Grants alternate m0, m1, m0, m1, m0, m1.
  - Responses return to the same sequence of masters.
- **Full stall.** MAX_OUTSTANDING=4, s_r_valid_i held 0, m1 issues 6 writes.
  - 4 grants, then m1_gnt_o=0.
  - After one s_r_valid_i, exactly one additional grant follows ≥1 cycle later.
  - Count never exceeds 4.
- **Grant wait.** s_gnt_i=0 for 3 cycles while m0 requests; m1 raises req in cycle 2.
  - s_add_o stays m0's address; m0 granted on cycle 4.
  - m1 is granted next.
- **Spurious response.** s_r_valid_i=1 with empty FIFO.
  - No m*_r_valid_o; err_o=1 until rst_i.
  - Reset clears err_o to 0.
- **Reset mid-flight.** 3 outstanding reads, rst_i pulsed for 1 cycle, then 3 late s_r_valid_i.
  - The late responses are dropped and err_o=1.
  - A subsequent m1 read routes correctly to m1.

Source files
------------

// File: rtl/l2_lint_arbiter.sv
// l2_lint_arbiter
// Shares one single-port L2 bank lint slave between two lint masters.
// Master 0 is the JTAG lint master, master 1 a second SoC requester
// (for example a test DMA). Requests are arbitrated round-robin and
// forwarded combinationally. Responses come back in order and are routed
// through a small FIFO of master IDs that tracks outstanding transactions.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   m{0,1}_req_i/add_i/wen_i/be_i/wdata_i   master request channel
//   m{0,1}_gnt_o                  master grant
//   m{0,1}_r_valid_o/r_rdata_o    master response channel
//   s_req_o/add_o/wen_o/be_o/wdata_o        request channel to L2
//   s_gnt_i                       L2 grant
//   s_r_valid_i/s_r_rdata_i       L2 response channel
//   err_o                         sticky flag: response seen with no outstanding ID
module l2_lint_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RESET_PRIO      = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,

  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_add_i,
  input  logic                    m0_wen_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_r_valid_o,
  output logic [DATA_WIDTH-1:0]   m0_r_rdata_o,

  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_add_i,
  input  logic                    m1_wen_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_r_valid_o,
  output logic [DATA_WIDTH-1:0]   m1_r_rdata_o,

  output logic                    s_req_o,
  output logic [ADDR_WIDTH-1:0]   s_add_o,
  output logic                    s_wen_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_gnt_i,
  input  logic                    s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]   s_r_rdata_i,

  output logic                    err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Outstanding-transaction ID FIFO, arbitration and error state
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic [PTR_W-1:0]           wr_ptr_q;
  logic [PTR_W-1:0]           rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic                       rr_ptr_q;
  logic                       lock_q;
  logic                       lock_id_q;
  logic                       err_q;

  logic fifo_full;
  logic fifo_empty;
  logic elig0;
  logic elig1;
  logic sel_valid;
  logic sel_id;
  logic accept;
  logic pop;
  logic spurious;
  logic head_id;

  // Fullness uses the registered count only, so a pop in the same cycle
  // never re-opens the request path; a full stall always costs a cycle.
  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);

  assign elig0 = m0_req_i && !fifo_full && !rst_i;
  assign elig1 = m1_req_i && !fifo_full && !rst_i;

  // Master selection. A request that was presented but not granted last
  // cycle keeps the bus, so the slave sees stable fields until the
  // handshake completes even if the other master becomes eligible.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = 1'b0;
    if (lock_q && (lock_id_q ? elig1 : elig0)) begin
      sel_valid = 1'b1;
      sel_id    = lock_id_q;
    end else if (elig0 && elig1) begin
      sel_valid = 1'b1;
      sel_id    = rr_ptr_q;
    end else if (elig0) begin
      sel_valid = 1'b1;
      sel_id    = 1'b0;
    end else if (elig1) begin
      sel_valid = 1'b1;
      sel_id    = 1'b1;
    end
  end

  // Request mux towards L2; an idle bus drives all-zero fields.
  always_comb begin
    s_req_o   = sel_valid;
    s_add_o   = '0;
    s_wen_o   = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (sel_valid) begin
      if (sel_id) begin
        s_add_o   = m1_add_i;
        s_wen_o   = m1_wen_i;
        s_be_o    = m1_be_i;
        s_wdata_o = m1_wdata_i;
      end else begin
        s_add_o   = m0_add_i;
        s_wen_o   = m0_wen_i;
        s_be_o    = m0_be_i;
        s_wdata_o = m0_wdata_i;
      end
    end
  end

  assign m0_gnt_o = sel_valid && !sel_id && s_gnt_i;
  assign m1_gnt_o = sel_valid &&  sel_id && s_gnt_i;
  assign accept   = sel_valid && s_gnt_i;

  // Responses are routed to the master at the FIFO head; a response with
  // nothing outstanding (including ones that survived a reset) is dropped.
  assign head_id  = id_q[rd_ptr_q];
  assign pop      = s_r_valid_i && !fifo_empty && !rst_i;
  assign spurious = s_r_valid_i && fifo_empty;

  assign m0_r_valid_o = pop && !head_id;
  assign m1_r_valid_o = pop &&  head_id;
  assign m0_r_rdata_o = (pop && !head_id) ? s_r_rdata_i : '0;
  assign m1_r_rdata_o = (pop &&  head_id) ? s_r_rdata_i : '0;

  assign err_o = err_q;

  // FIFO pointers/count, round-robin pointer, grant lock and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rr_ptr_q  <= RESET_PRIO[0];
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        id_q[wr_ptr_q] <= sel_id;
        wr_ptr_q       <= wr_ptr_q + 1'b1;
        rr_ptr_q       <= ~sel_id;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      lock_q    <= sel_valid && !s_gnt_i;
      lock_id_q <= sel_id;
      if (spurious) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_l2_lint_arbiter.sv
// tb_l2_lint_arbiter
// Self-checking bench for l2_lint_arbiter. A queue-based model of the
// outstanding masters, the round-robin winner and the sticky error flag
// predicts every output on every falling edge. Directed scenarios add
// literal expectations, then a randomized phase exercises the rest.
module tb_l2_lint_arbiter;

  localparam int MAXO = 4;
  localparam int PRIO = 0;

  logic        clk;
  logic        rst;
  logic        mReq   [2];
  logic [31:0] mAdd   [2];
  logic        mWen   [2];
  logic [3:0]  mBe    [2];
  logic [31:0] mWdata [2];
  logic        sGnt;
  logic        sRvalid;
  logic [31:0] sRdata;

  logic        m0Gnt, m1Gnt, m0Rv, m1Rv;
  logic [31:0] m0Rd, m1Rd;
  logic        sReq, sWen, err;
  logic [31:0] sAdd, sWdata;
  logic [3:0]  sBe;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int   modelQ[$];
  int   modelRr   = PRIO;
  logic modelErr  = 1'b0;
  logic modelLock = 1'b0;
  int   modelLockId = 0;
  logic lastGnt [2];

  l2_lint_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO), .RESET_PRIO(PRIO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(mReq[0]), .m0_add_i(mAdd[0]), .m0_wen_i(mWen[0]), .m0_be_i(mBe[0]),
    .m0_wdata_i(mWdata[0]), .m0_gnt_o(m0Gnt), .m0_r_valid_o(m0Rv), .m0_r_rdata_o(m0Rd),
    .m1_req_i(mReq[1]), .m1_add_i(mAdd[1]), .m1_wen_i(mWen[1]), .m1_be_i(mBe[1]),
    .m1_wdata_i(mWdata[1]), .m1_gnt_o(m1Gnt), .m1_r_valid_o(m1Rv), .m1_r_rdata_o(m1Rd),
    .s_req_o(sReq), .s_add_o(sAdd), .s_wen_o(sWen), .s_be_o(sBe), .s_wdata_o(sWdata),
    .s_gnt_i(sGnt), .s_r_valid_i(sRvalid), .s_r_rdata_i(sRdata),
    .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge and drive one cycle of inputs.
  task automatic applyStimulus(input logic r0, input logic [31:0] a0, input logic w0,
                               input logic r1, input logic [31:0] a1, input logic w1,
                               input logic sg, input logic sv, input logic [31:0] sd);
    @(posedge clk);
    #1;
    mReq[0] = r0; mAdd[0] = a0; mWen[0] = w0; mBe[0] = 4'hF; mWdata[0] = a0 ^ 32'hA5A5_0000;
    mReq[1] = r1; mAdd[1] = a1; mWen[1] = w1; mBe[1] = 4'h3; mWdata[1] = a1 ^ 32'h0000_5A5A;
    sGnt = sg; sRvalid = sv; sRdata = sd;
    #1;
  endtask

  task automatic resetDut(input int n);
    rst = 1'b1;
    repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // Model check on every falling edge: predict outputs from the current
  // inputs and the model state, then advance the model to the next edge.
  always @(negedge clk) begin : compareProc
    int          sel;
    int          head;
    logic        full, e0, e1;
    logic [31:0] eAdd, eWdata, eRd0, eRd1;
    logic        eWen, eRv0, eRv1;
    logic [3:0]  eBe;
    if (rst) begin
      checkOutput("rst_gnt0",   64'(m0Gnt), 64'(0));
      checkOutput("rst_gnt1",   64'(m1Gnt), 64'(0));
      checkOutput("rst_sreq",   64'(sReq),  64'(0));
      checkOutput("rst_rv0",    64'(m0Rv),  64'(0));
      checkOutput("rst_rv1",    64'(m1Rv),  64'(0));
      checkOutput("rst_err",    64'(err),   64'(modelErr));
      modelQ.delete();
      modelRr     = PRIO;
      modelErr    = 1'b0;
      modelLock   = 1'b0;
      modelLockId = 0;
      lastGnt[0]  = 1'b0;
      lastGnt[1]  = 1'b0;
    end else begin
      full = (modelQ.size() >= MAXO);
      e0   = mReq[0] && !full;
      e1   = mReq[1] && !full;
      sel  = -1;
      if (modelLock && ((modelLockId == 0) ? e0 : e1)) sel = modelLockId;
      else if (e0 && e1) sel = modelRr;
      else if (e0)       sel = 0;
      else if (e1)       sel = 1;
      eAdd = '0; eWen = 1'b0; eBe = '0; eWdata = '0;
      if (sel >= 0) begin
        eAdd = mAdd[sel]; eWen = mWen[sel]; eBe = mBe[sel]; eWdata = mWdata[sel];
      end
      checkOutput("sreq",  64'(sReq),   64'(sel >= 0));
      checkOutput("sadd",  64'(sAdd),   64'(eAdd));
      checkOutput("swen",  64'(sWen),   64'(eWen));
      checkOutput("sbe",   64'(sBe),    64'(eBe));
      checkOutput("swdat", 64'(sWdata), 64'(eWdata));
      checkOutput("gnt0",  64'(m0Gnt),  64'((sel == 0) && sGnt));
      checkOutput("gnt1",  64'(m1Gnt),  64'((sel == 1) && sGnt));

      eRv0 = 1'b0; eRv1 = 1'b0; eRd0 = '0; eRd1 = '0; head = -1;
      if (sRvalid && modelQ.size() > 0) begin
        head = modelQ[0];
        if (head == 0) begin eRv0 = 1'b1; eRd0 = sRdata; end
        else           begin eRv1 = 1'b1; eRd1 = sRdata; end
      end
      checkOutput("rv0",   64'(m0Rv), 64'(eRv0));
      checkOutput("rv1",   64'(m1Rv), 64'(eRv1));
      checkOutput("rd0",   64'(m0Rd), 64'(eRd0));
      checkOutput("rd1",   64'(m1Rd), 64'(eRd1));
      checkOutput("err",   64'(err),  64'(modelErr));

      if (sRvalid) begin
        if (head >= 0) void'(modelQ.pop_front());
        else           modelErr = 1'b1;
      end
      if (sel >= 0 && sGnt) begin
        modelQ.push_back(sel);
        modelRr = 1 - sel;
      end
      modelLock   = (sel >= 0) && !sGnt;
      modelLockId = (sel >= 0) ? sel : 0;
      lastGnt[0]  = (sel == 0) && sGnt;
      lastGnt[1]  = (sel == 1) && sGnt;
    end
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mReq[k] = 1'b0; mAdd[k] = '0; mWen[k] = 1'b0; mBe[k] = '0; mWdata[k] = '0;
      lastGnt[k] = 1'b0;
    end
    sGnt = 1'b0; sRvalid = 1'b0; sRdata = '0;
    resetDut(2);
    checkOutput("lit_reset_err",  64'(err),  64'(0));
    checkOutput("lit_reset_sreq", 64'(sReq), 64'(0));

    // Single master read
    applyStimulus(1, 32'h1C00_0010, 1, 0, 0, 0, 1, 0, 0);
    checkOutput("lit_rd_gnt0", 64'(m0Gnt), 64'(1));
    checkOutput("lit_rd_add",  64'(sAdd),  64'(32'h1C00_0010));
    checkOutput("lit_rd_gnt1", 64'(m1Gnt), 64'(0));
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    checkOutput("lit_rd_rv0",  64'(m0Rv), 64'(1));
    checkOutput("lit_rd_data", 64'(m0Rd), 64'(32'hDEAD_BEEF));
    checkOutput("lit_rd_rv1",  64'(m1Rv), 64'(0));
    checkOutput("lit_rd_err",  64'(err),  64'(0));

    // Contention: both masters request, responses return one cycle later
    resetDut(1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(i < 6, 32'h1000 + 32'(i * 4), 1, i < 6, 32'h2000 + 32'(i * 4), 0,
                    1, i > 0, 32'h5000 + 32'(i));
      if (i < 6) begin
        checkOutput("lit_rr_gnt0", 64'(m0Gnt), 64'(i % 2 == 0));
        checkOutput("lit_rr_gnt1", 64'(m1Gnt), 64'(i % 2 == 1));
      end
      if (i > 0) begin
        checkOutput("lit_rr_rv0", 64'(m0Rv), 64'((i - 1) % 2 == 0));
        checkOutput("lit_rr_rv1", 64'(m1Rv), 64'((i - 1) % 2 == 1));
      end
    end

    // Full stall: m1 writes with no responses returning
    resetDut(1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 1, 32'h100 + 32'((i < 4 ? i : 4) * 4), 0, 1, 0, 0);
      checkOutput("lit_full_gnt1", 64'(m1Gnt), 64'(i < 4));
    end
    applyStimulus(0, 0, 0, 1, 32'h110, 0, 1, 1, 32'h77);
    checkOutput("lit_full_popgnt", 64'(m1Gnt), 64'(0));
    checkOutput("lit_full_poprv",  64'(m1Rv),  64'(1));
    applyStimulus(0, 0, 0, 1, 32'h110, 0, 1, 0, 0);
    checkOutput("lit_full_regnt",  64'(m1Gnt), 64'(1));
    applyStimulus(0, 0, 0, 1, 32'h114, 0, 1, 0, 0);
    checkOutput("lit_full_again",  64'(m1Gnt), 64'(0));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 32'h80 + 32'(i));
      checkOutput("lit_full_drain", 64'(m1Rv), 64'(1));
    end

    // Grant wait: L2 withholds grant while m0 requests, m1 joins later
    resetDut(1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'hAAA0, 1, i >= 1, 32'hBBB0, 1, 0, 0, 0);
      checkOutput("lit_wait_add",  64'(sAdd),  64'(32'hAAA0));
      checkOutput("lit_wait_gnt0", 64'(m0Gnt), 64'(0));
    end
    applyStimulus(1, 32'hAAA0, 1, 1, 32'hBBB0, 1, 1, 0, 0);
    checkOutput("lit_wait_gnt0b", 64'(m0Gnt), 64'(1));
    applyStimulus(0, 0, 0, 1, 32'hBBB0, 1, 1, 0, 0);
    checkOutput("lit_wait_gnt1",  64'(m1Gnt), 64'(1));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
    checkOutput("lit_wait_rv0", 64'(m0Rv), 64'(1));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h2);
    checkOutput("lit_wait_rv1", 64'(m1Rv), 64'(1));

    // Selection lock: m1 holds the bus against a higher-priority m0
    resetDut(1);
    applyStimulus(0, 0, 0, 1, 32'hCCC0, 1, 0, 0, 0);
    checkOutput("lit_lock_add0", 64'(sAdd), 64'(32'hCCC0));
    applyStimulus(1, 32'hDDD0, 1, 1, 32'hCCC0, 1, 0, 0, 0);
    checkOutput("lit_lock_add1", 64'(sAdd), 64'(32'hCCC0));
    applyStimulus(1, 32'hDDD0, 1, 1, 32'hCCC0, 1, 1, 0, 0);
    checkOutput("lit_lock_gnt1", 64'(m1Gnt), 64'(1));
    applyStimulus(1, 32'hDDD0, 1, 0, 0, 0, 1, 1, 32'h3);
    checkOutput("lit_lock_gnt0", 64'(m0Gnt), 64'(1));
    checkOutput("lit_lock_rv1",  64'(m1Rv),  64'(1));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h4);
    checkOutput("lit_lock_rv0",  64'(m0Rv),  64'(1));

    // Spurious response
    resetDut(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234);
    checkOutput("lit_sp_rv0", 64'(m0Rv), 64'(0));
    checkOutput("lit_sp_rv1", 64'(m1Rv), 64'(0));
    checkOutput("lit_sp_err0", 64'(err), 64'(0));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("lit_sp_err1", 64'(err), 64'(1));
    end
    resetDut(1);
    checkOutput("lit_sp_clr", 64'(err), 64'(0));

    // Reset mid-flight
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h300 + 32'(i * 4), 1, 0, 0, 0, 1, 0, 0);
      checkOutput("lit_mid_gnt0", 64'(m0Gnt), 64'(1));
    end
    resetDut(1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h900 + 32'(i));
      checkOutput("lit_mid_rv0", 64'(m0Rv), 64'(0));
      checkOutput("lit_mid_rv1", 64'(m1Rv), 64'(0));
    end
    applyStimulus(0, 0, 0, 1, 32'h400, 1, 1, 0, 0);
    checkOutput("lit_mid_err",  64'(err),   64'(1));
    checkOutput("lit_mid_gnt1", 64'(m1Gnt), 64'(1));
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D);
    checkOutput("lit_mid_rv1b", 64'(m1Rv), 64'(1));
    checkOutput("lit_mid_rd1",  64'(m1Rd), 64'(32'hCAFE_F00D));

    // Randomized traffic; masters hold fields until granted, L2 answers in order
    resetDut(1);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 599) == 0);
      for (int k = 0; k < 2; k++) begin
        if (!mReq[k] || lastGnt[k]) begin
          mReq[k]   = ($urandom_range(0, 2) != 0);
          mAdd[k]   = $urandom;
          mWen[k]   = 1'($urandom_range(0, 1));
          mBe[k]    = 4'($urandom);
          mWdata[k] = $urandom;
        end
      end
      sGnt    = ($urandom_range(0, 3) != 0);
      sRvalid = (modelQ.size() > 0) && ($urandom_range(0, 2) != 0);
      sRdata  = $urandom;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mReq[0] = 1'b0; mReq[1] = 1'b0; sRvalid = 1'b0; sGnt = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
